spi_xfer_ctrl: RTL and testbench

//  Multi-byte SPI transaction sequencer sitting between a host/register block and the byte-level SPI master engine.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_cs_timer.sv | 29 ++
 rtl/spi_xfer_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and default chip-select timing
// shared by the SPI transaction sequencer and its timer.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;

  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_CS_IDLE  = 4;

  localparam int TMR_W = 8;

endpackage

// File: rtl/spi_cs_timer.sv
// spi_cs_timer: loadable saturating down-counter; done while
// the count is at or below one, so a load of N spans N cycles.
module spi_cs_timer
  import spi_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_Load,
  input  logic [W-1:0] i_Val,
  output logic         o_Done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_cnt <= '0;
    end else if (i_Load) begin
      r_cnt <= i_Val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_Done = (r_cnt <= W'(1));

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: multi-byte SPI transaction sequencer between a
// host and a byte-level SPI engine; owns chip-select timing.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int NUM_CS        = 2,
  parameter int CS_W          = 1,
  parameter int LEN_W         = 8,
  parameter int CS_SETUP_CLKS = DEF_CS_SETUP,
  parameter int CS_HOLD_CLKS  = DEF_CS_HOLD,
  parameter int CS_IDLE_CLKS  = DEF_CS_IDLE
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Xfer_Start,
  input  logic [LEN_W-1:0]  i_Xfer_Len,
  input  logic [CS_W-1:0]   i_Xfer_CS,
  output logic              o_Busy,
  output logic              o_Xfer_Done,
  output logic              o_Xfer_Err,
  input  logic [7:0]        i_TX_Byte,
  input  logic              i_TX_Valid,
  output logic              o_TX_Ready,
  output logic [7:0]        o_RX_Byte,
  output logic              o_RX_DV,
  output logic [7:0]        o_M_TX_Byte,
  output logic              o_M_TX_DV,
  input  logic              i_M_TX_Ready,
  input  logic              i_M_RX_DV,
  input  logic [7:0]        i_M_RX_Byte,
  output logic [NUM_CS-1:0] o_SPI_CS_n
);

  logic [2:0]        r_state;
  logic [LEN_W-1:0]  r_rem;
  logic [NUM_CS-1:0] r_cs_n;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_rx_dv;
  logic [7:0]        r_rx_byte;
  logic              r_m_tx_dv;
  logic [7:0]        r_m_tx_byte;

  logic              w_start_ok;
  logic              w_last;
  logic              w_tx_ready;
  logic [NUM_CS-1:0] w_cs_sel;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_done;

  assign w_start_ok = (i_Xfer_Len != '0) &&
                      (32'(i_Xfer_CS) < 32'(NUM_CS));
  assign w_last     = (r_rem == LEN_W'(1));
  assign w_tx_ready = (r_state == ST_LOAD) && i_M_TX_Ready;

  always_comb begin
    w_cs_sel = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      w_cs_sel[i] = (32'(i_Xfer_CS) == 32'(i));
    end
  end

  // One timer serves SETUP, HOLD and GAP; it is loaded on entry.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_Xfer_Start && w_start_ok) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(CS_SETUP_CLKS);
        end
      end
      ST_WAIT: begin
        if (i_M_RX_DV && w_last) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(CS_HOLD_CLKS);
        end
      end
      ST_HOLD: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(CS_IDLE_CLKS);
        end
      end
      default: ;
    endcase
  end

  spi_cs_timer #(
    .W(TMR_W)
  ) u_tmr (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Load  (w_tmr_load),
    .i_Val   (w_tmr_val),
    .o_Done  (w_tmr_done)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_cs_n      <= '1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rx_dv     <= 1'b0;
      r_rx_byte   <= 8'h00;
      r_m_tx_dv   <= 1'b0;
      r_m_tx_byte <= 8'h00;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rx_dv   <= 1'b0;
      r_m_tx_dv <= 1'b0;
      if (i_Xfer_Start && r_busy) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_Xfer_Start) begin
            if (w_start_ok) begin
              r_rem   <= i_Xfer_Len;
              r_cs_n  <= ~w_cs_sel;
              r_busy  <= 1'b1;
              r_state <= ST_SETUP;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (w_tmr_done) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_TX_Valid && w_tx_ready) begin
            r_m_tx_byte <= i_TX_Byte;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_M_TX_Ready) begin
            r_m_tx_dv <= 1'b1;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_M_RX_DV) begin
            r_rx_byte <= i_M_RX_Byte;
            r_rx_dv   <= 1'b1;
            r_rem     <= r_rem - 1'b1;
            r_state   <= w_last ? ST_HOLD : ST_LOAD;
          end
        end
        ST_HOLD: begin
          if (w_tmr_done) begin
            r_cs_n  <= '1;
            r_done  <= 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_tmr_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_Busy      = r_busy;
  assign o_Xfer_Done = r_done;
  assign o_Xfer_Err  = r_err;
  assign o_TX_Ready  = w_tx_ready;
  assign o_RX_Byte   = r_rx_byte;
  assign o_RX_DV     = r_rx_dv;
  assign o_M_TX_Byte = r_m_tx_byte;
  assign o_M_TX_DV   = r_m_tx_dv;
  assign o_SPI_CS_n  = r_cs_n;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed bench with a behavioural byte
// engine, a host feeder and a negedge event monitor.
module tb_spi_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic [1:0] cs;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       m_ready;
  logic       m_rx_dv;
  logic [7:0] m_rx_byte;
  logic       busy, done, err, tx_ready, rx_dv, m_tx_dv;
  logic [7:0] rx_byte, m_tx_byte;
  logic [1:0] cs_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .NUM_CS(2), .CS_W(2), .LEN_W(8),
    .CS_SETUP_CLKS(2), .CS_HOLD_CLKS(2), .CS_IDLE_CLKS(4)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Xfer_Start(start), .i_Xfer_Len(len), .i_Xfer_CS(cs),
    .o_Busy(busy), .o_Xfer_Done(done), .o_Xfer_Err(err),
    .i_TX_Byte(tx_byte), .i_TX_Valid(tx_valid),
    .o_TX_Ready(tx_ready),
    .o_RX_Byte(rx_byte), .o_RX_DV(rx_dv),
    .o_M_TX_Byte(m_tx_byte), .o_M_TX_DV(m_tx_dv),
    .i_M_TX_Ready(m_ready), .i_M_RX_DV(m_rx_dv),
    .i_M_RX_Byte(m_rx_byte),
    .o_SPI_CS_n(cs_n)
  );

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int  cyc = 0;
  int  host_acc, mtx_cnt, done_cnt, err_cnt, cs_low_evt;
  int  cs_low_cyc, cs_high_cyc, first_mtx_cyc;
  int  last_rxdv_cyc, done_cyc, busy_fall_cyc;
  int  bad_dv = 0;
  int  bad_cs = 0;
  logic [1:0] cs_low_val;

  task automatic clr();
    rx_q.delete();
    host_acc = 0; mtx_cnt = 0; done_cnt = 0;
    err_cnt = 0; cs_low_evt = 0;
    cs_low_cyc = -1; cs_high_cyc = -1;
    first_mtx_cyc = -1; last_rxdv_cyc = -1;
    done_cyc = -1; busy_fall_cyc = -1;
    cs_low_val = 2'b11;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte engine: Ready drops a cycle after DV, echo 20 later.
  initial begin : engine
    logic [7:0] b;
    m_ready = 1'b1; m_rx_dv = 1'b0; m_rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (m_tx_dv === 1'b1) begin
        b = m_tx_byte;
        @(negedge clk); m_ready = 1'b0;
        repeat (19) @(negedge clk);
        m_rx_byte = b; m_rx_dv = 1'b1;
        @(negedge clk); m_rx_dv = 1'b0;
        @(negedge clk); m_ready = 1'b1;
      end
    end
  end

  initial begin : feeder
    logic commit;
    logic [7:0] tmp;
    commit = 1'b0; tx_valid = 1'b0; tx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (commit && tx_q.size() > 0) begin
        tmp = tx_q.pop_front();
        host_acc++;
      end
      tx_valid = (tx_q.size() > 0);
      tx_byte  = tx_valid ? tx_q[0] : 8'h00;
      #1 commit = tx_valid && (tx_ready === 1'b1) && rst_n;
    end
  end

  initial begin : monitor
    logic [1:0] pcs;
    logic pbusy;
    pcs = 2'b11; pbusy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rx_dv === 1'b1) begin
        rx_q.push_back(rx_byte);
        last_rxdv_cyc = cyc;
      end
      if (m_tx_dv === 1'b1) begin
        mtx_cnt++;
        if (first_mtx_cyc < 0) first_mtx_cyc = cyc;
        if (m_ready !== 1'b1) bad_dv++;
      end
      if (pcs == 2'b11 && cs_n != 2'b11) begin
        cs_low_evt++; cs_low_cyc = cyc; cs_low_val = cs_n;
      end
      if (pcs != 2'b11 && cs_n == 2'b11) cs_high_cyc = cyc;
      if (cs_n == 2'b00) bad_cs++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (err === 1'b1) err_cnt++;
      if (pbusy && busy === 1'b0) busy_fall_cyc = cyc;
      pcs = cs_n; pbusy = busy;
    end
  end

  task automatic go(input logic [7:0] l, input logic [1:0] c);
    start = 1'b1; len = l; cs = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk); n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'h00; cs = 2'b00;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_n, 2'b11);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, err, rx_dv, m_tx_dv}, 0);
    chk("rst_bytes", {rx_byte, m_tx_byte}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three-byte transaction on CS1
    clr();
    tx_q = '{8'hA5, 8'h3C, 8'hFF};
    go(8'd3, 2'd1);
    chk("t1_busy", busy, 1);
    wait_idle("t1_tmo");
    chk("t1_cs", cs_low_val, 2'b01);
    chk("t1_nrx", rx_q.size(), 3);
    chk("t1_rx", {rx_q[0], rx_q[1], rx_q[2]}, 24'hA53CFF);
    chk("t1_done", done_cnt, 1);
    chk("t1_mtx", mtx_cnt, 3);
    chk("t1_host", host_acc, 3);
    chk("t1_err", err_cnt, 0);
    chk("t1_csend", cs_n, 2'b11);

    // Single byte: setup/hold/gap timing
    clr();
    tx_q = '{8'h5A};
    go(8'd1, 2'd0);
    wait_idle("t2_tmo");
    chk("t2_cs", cs_low_val, 2'b10);
    chk("t2_setup", first_mtx_cyc - cs_low_cyc, 4);
    chk("t2_hold", cs_high_cyc - last_rxdv_cyc, 2);
    chk("t2_donecyc", done_cyc - cs_high_cyc, 0);
    chk("t2_gap", busy_fall_cyc - cs_high_cyc, 4);
    chk("t2_rx", rx_q.size() == 1 ? rx_q[0] : 8'hxx, 8'h5A);

    // Illegal starts
    clr();
    go(8'd0, 2'd0);
    repeat (2) @(negedge clk);
    go(8'd1, 2'd2);
    repeat (3) @(negedge clk);
    chk("t3_err", err_cnt, 2);
    chk("t3_cslow", cs_low_evt, 0);
    chk("t3_busy", busy, 0);
    chk("t3_cs", cs_n, 2'b11);

    // Host underflow before byte two
    clr();
    tx_q = '{8'h11};
    go(8'd2, 2'd1);
    begin
      int n;
      n = 0;
      while (rx_q.size() < 1 && n < 500) begin
        @(negedge clk); n++;
      end
    end
    chk("t4_rx1", rx_q.size(), 1);
    repeat (50) @(negedge clk);
    chk("t4_mtx_stall", mtx_cnt, 1);
    chk("t4_cs_stall", cs_n, 2'b01);
    chk("t4_busy_stall", busy, 1);
    tx_q.push_back(8'h22);
    wait_idle("t4_tmo");
    chk("t4_nrx", rx_q.size(), 2);
    chk("t4_rx", {rx_q[0], rx_q[1]}, 16'h1122);
    chk("t4_done", done_cnt, 1);

    // Start while busy is rejected
    clr();
    tx_q = '{8'h77};
    go(8'd1, 2'd0);
    repeat (8) @(negedge clk);
    go(8'd2, 2'd1);
    repeat (2) @(negedge clk);
    chk("t5_err", err_cnt, 1);
    wait_idle("t5_tmo");
    chk("t5_nrx", rx_q.size(), 1);
    chk("t5_cs", cs_low_val, 2'b10);
    chk("t5_done", done_cnt, 1);
    chk("t5_host", host_acc, 1);
    clr();
    tx_q = '{8'h6B};
    go(8'd1, 2'd1);
    chk("t5_accept", busy, 1);
    wait_idle("t5b_tmo");
    chk("t5b_err", err_cnt, 0);
    chk("t5b_cs", cs_low_val, 2'b01);

    // Reset mid-WAIT
    clr();
    tx_q = '{8'h31, 8'h32};
    go(8'd2, 2'd1);
    begin
      int n;
      n = 0;
      while (mtx_cnt < 1 && n < 200) begin
        @(negedge clk); n++;
      end
    end
    repeat (5) @(negedge clk);
    chk("t6_pre_cs", cs_n, 2'b01);
    rst_n = 1'b0;
    tx_q.delete();
    #1;
    chk("t6_cs", cs_n, 2'b11);
    chk("t6_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    clr();
    tx_q = '{8'h99};
    go(8'd1, 2'd0);
    wait_idle("t6_tmo");
    chk("t6_rx", rx_q.size() == 1 ? rx_q[0] : 8'hxx, 8'h99);
    chk("t6_done", done_cnt, 1);
    chk("t6_cs_n", cs_low_val, 2'b10);

    chk("glob_dv_ready", bad_dv, 0);
    chk("glob_cs_onehot", bad_cs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
